// File: rtl/picnic_sig_packer.sv
// rtl/picnic_sig_packer.sv - Picnic/KKW signature frame assembler with challenge validation
// Validates the challenge list, sorts repetitions into hidden/opened slots and streams the frame MSB-first.
module picnic_sig_packer #(
    parameter int M     = 8,
    parameter int TAU   = 4,
    parameter int IDXW  = 5,
    parameter int SEEDW = 128,
    parameter int CVW   = 256,
    parameter int ZW    = 4864,
    parameter int OUTW  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TAU*IDXW-1:0]   lc,
    input  logic [255:0]          h_t,
    input  logic [255:0]          salt,
    input  logic [127:0]          seed_tri,
    input  logic [M*SEEDW-1:0]    seed_star,
    input  logic [M*CVW-1:0]      cv,
    input  logic [M*ZW-1:0]       z,
    output logic [OUTW-1:0]       out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int NH       = M - TAU;
    localparam int TOTW     = 640 + NH*(SEEDW+CVW) + TAU*ZW;
    localparam int NBEATS   = (TOTW + OUTW - 1) / OUTW;
    localparam int SHW      = NBEATS * OUTW;
    localparam int RW       = $clog2(M);
    localparam int TW       = (TAU > 1) ? $clog2(TAU) : 1;
    localparam int HW       = (NH > 1) ? $clog2(NH) : 1;
    localparam int BW       = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF_SEED = SHW - 512;
    localparam int OFF_CV   = OFF_SEED - NH*SEEDW;
    localparam int OFF_Z    = OFF_CV - NH*CVW;
    localparam int OFF_TRI  = OFF_Z - TAU*ZW;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CLASSIFY, S_LOAD, S_STREAM, S_DONE, S_ERR
    } state_t;

    state_t            state, next_state;
    logic [TW-1:0]     chk_cnt;
    logic [RW-1:0]     rep_cnt;
    logic [HW-1:0]     hid_cnt;
    logic [TW-1:0]     z_cnt;
    logic [BW-1:0]     beat_cnt;
    logic [M-1:0]      mask;
    logic              bad;
    logic              err_r;
    logic [255:0]      h_t_r;
    logic [255:0]      salt_r;
    logic [127:0]      tri_r;
    logic [SEEDW-1:0]  seed_slot [NH];
    logic [CVW-1:0]    cv_slot   [NH];
    logic [ZW-1:0]     z_slot    [TAU];
    logic [SHW-1:0]    shreg;
    logic [SHW-1:0]    frame;

    logic [IDXW-1:0]   lc_entry;
    logic [RW-1:0]     lc_idx;
    logic              entry_bad;
    logic              chk_last, rep_last, beat_last;

    // LC[0] sits in the MSBs, so entry i is counted down from the top.
    assign lc_entry  = lc[(TAU-1-int'(chk_cnt))*IDXW +: IDXW];
    assign lc_idx    = lc_entry[RW-1:0];
    assign entry_bad = (32'(lc_entry) >= M) || mask[lc_idx];
    assign chk_last  = (chk_cnt == TW'(TAU-1));
    assign rep_last  = (rep_cnt == RW'(M-1));
    assign beat_last = (beat_cnt == BW'(NBEATS-1));
    assign out_data  = shreg[SHW-1 -: OUTW];
    assign err       = err_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_CHECK;
            S_CHECK:    if (chk_last) next_state = (bad || entry_bad) ? S_ERR : S_CLASSIFY;
            S_CLASSIFY: if (rep_last) next_state = S_LOAD;
            S_LOAD:     next_state = S_STREAM;
            S_STREAM:   if (out_ready && beat_last) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            S_ERR:      next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:   ;
            S_STREAM: begin
                out_valid = 1'b1;
                out_last  = beat_last;
                busy      = 1'b1;
            end
            S_DONE, S_ERR: done = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

    always_comb begin
        frame = '0;
        frame[SHW-1 -: 256]   = h_t_r;
        frame[SHW-257 -: 256] = salt_r;
        for (int k = 0; k < NH; k++) begin
            frame[OFF_SEED-1-k*SEEDW -: SEEDW] = seed_slot[k];
            frame[OFF_CV-1-k*CVW -: CVW]       = cv_slot[k];
        end
        for (int k = 0; k < TAU; k++)
            frame[OFF_Z-1-k*ZW -: ZW] = z_slot[k];
        frame[OFF_TRI-1 -: 128] = tri_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_cnt  <= '0;
            rep_cnt  <= '0;
            hid_cnt  <= '0;
            z_cnt    <= '0;
            beat_cnt <= '0;
            mask     <= '0;
            bad      <= 1'b0;
            err_r    <= 1'b0;
            h_t_r    <= '0;
            salt_r   <= '0;
            tri_r    <= '0;
            shreg    <= '0;
            for (int k = 0; k < NH; k++) begin
                seed_slot[k] <= '0;
                cv_slot[k]   <= '0;
            end
            for (int k = 0; k < TAU; k++)
                z_slot[k] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    err_r   <= 1'b0;
                    h_t_r   <= h_t;
                    salt_r  <= salt;
                    tri_r   <= seed_tri;
                    mask    <= '0;
                    bad     <= 1'b0;
                    chk_cnt <= '0;
                    rep_cnt <= '0;
                    hid_cnt <= '0;
                    z_cnt   <= '0;
                end
                S_CHECK: begin
                    if (entry_bad) bad <= 1'b1;
                    else           mask[lc_idx] <= 1'b1;
                    if (!chk_last) chk_cnt <= chk_cnt + 1'b1;
                    else if (bad || entry_bad) err_r <= 1'b1;
                end
                S_CLASSIFY: begin
                    if (mask[rep_cnt]) begin
                        z_slot[z_cnt] <= z[(M-1-int'(rep_cnt))*ZW +: ZW];
                        z_cnt         <= z_cnt + 1'b1;
                    end else begin
                        seed_slot[hid_cnt] <= seed_star[(M-1-int'(rep_cnt))*SEEDW +: SEEDW];
                        cv_slot[hid_cnt]   <= cv[(M-1-int'(rep_cnt))*CVW +: CVW];
                        hid_cnt            <= hid_cnt + 1'b1;
                    end
                    if (!rep_last) rep_cnt <= rep_cnt + 1'b1;
                end
                S_LOAD: begin
                    shreg    <= frame;
                    beat_cnt <= '0;
                end
                S_STREAM: if (out_ready) begin
                    shreg <= shreg << OUTW;
                    if (!beat_last) beat_cnt <= beat_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_picnic_sig_packer.sv
// tb/tb_picnic_sig_packer.sv - scoreboard bench for picnic_sig_packer
module tb_picnic_sig_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           a_start;
    logic [19:0]    a_lc;
    logic [255:0]   a_h_t, a_salt;
    logic [127:0]   a_tri;
    logic [1023:0]  a_seed;
    logic [2047:0]  a_cv;
    logic [38911:0] a_z;
    logic [63:0]    a_out_data;
    logic           a_out_valid, a_out_ready, a_out_last, a_busy, a_done, a_err;

    logic           b_start;
    logic [9:0]     b_lc;
    logic [2047:0]  b_seed;
    logic [4095:0]  b_cv;
    logic [77823:0] b_z;
    logic [99:0]    b_out_data;
    logic           b_out_valid, b_out_ready, b_out_last, b_busy, b_done, b_err;

    picnic_sig_packer dut_a (
        .clk(clk), .reset(reset), .start(a_start), .lc(a_lc), .h_t(a_h_t), .salt(a_salt),
        .seed_tri(a_tri), .seed_star(a_seed), .cv(a_cv), .z(a_z),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .busy(a_busy), .done(a_done), .err(a_err)
    );

    picnic_sig_packer #(.M(16), .TAU(2), .IDXW(5), .OUTW(100)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .lc(b_lc), .h_t(a_h_t), .salt(a_salt),
        .seed_tri(a_tri), .seed_star(b_seed), .cv(b_cv), .z(b_z),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .busy(b_busy), .done(b_done), .err(b_err)
    );

    int tests = 0;
    int fails = 0;
    int a_beats = 0;
    int b_beats = 0;
    bit a_rand_ready = 1'b0;
    bit fq[$];
    logic [99:0] exp_a[$], exp_b[$];
    bit exl_a[$], exl_b[$];
    logic        a_prev_stall = 1'b0;
    logic [63:0] a_prev_data;

    task automatic push_field(input logic [4863:0] v, input int w);
        for (int b = w - 1; b >= 0; b--) fq.push_back(v[b]);
    endtask

    task automatic gen_beats(input int outw, input bit to_b);
        logic [99:0] bt;
        while (fq.size() % outw != 0) fq.push_back(1'b0);
        while (fq.size() > 0) begin
            bt = '0;
            for (int b = outw - 1; b >= 0; b--) bt[b] = fq.pop_front();
            if (to_b) begin exp_b.push_back(bt); exl_b.push_back(fq.size() == 0); end
            else      begin exp_a.push_back(bt); exl_a.push_back(fq.size() == 0); end
        end
    endtask

    // Reference frame: hidden reps ascending, then opened reps ascending.
    task automatic model_a(input logic [19:0] lcv);
        logic [7:0] mk;
        int e;
        mk = '0;
        for (int i = 0; i < 4; i++) begin e = int'(lcv[(3-i)*5 +: 5]); mk[e] = 1'b1; end
        fq.delete();
        push_field(4864'(a_h_t), 256);
        push_field(4864'(a_salt), 256);
        for (int j = 0; j < 8; j++) if (!mk[j]) push_field(4864'(a_seed[(7-j)*128 +: 128]), 128);
        for (int j = 0; j < 8; j++) if (!mk[j]) push_field(4864'(a_cv[(7-j)*256 +: 256]), 256);
        for (int j = 0; j < 8; j++) if (mk[j])  push_field(a_z[(7-j)*4864 +: 4864], 4864);
        push_field(4864'(a_tri), 128);
        gen_beats(64, 1'b0);
    endtask

    task automatic model_b(input logic [9:0] lcv);
        logic [15:0] mk;
        int e;
        mk = '0;
        for (int i = 0; i < 2; i++) begin e = int'(lcv[(1-i)*5 +: 5]); mk[e] = 1'b1; end
        fq.delete();
        push_field(4864'(a_h_t), 256);
        push_field(4864'(a_salt), 256);
        for (int j = 0; j < 16; j++) if (!mk[j]) push_field(4864'(b_seed[(15-j)*128 +: 128]), 128);
        for (int j = 0; j < 16; j++) if (!mk[j]) push_field(4864'(b_cv[(15-j)*256 +: 256]), 256);
        for (int j = 0; j < 16; j++) if (mk[j])  push_field(b_z[(15-j)*4864 +: 4864], 4864);
        push_field(4864'(a_tri), 128);
        gen_beats(100, 1'b1);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++)    begin a_h_t[i*32 +: 32] = $urandom(); a_salt[i*32 +: 32] = $urandom(); end
        for (int i = 0; i < 4; i++)    a_tri[i*32 +: 32] = $urandom();
        for (int i = 0; i < 32; i++)   a_seed[i*32 +: 32] = $urandom();
        for (int i = 0; i < 64; i++)   a_cv[i*32 +: 32] = $urandom();
        for (int i = 0; i < 1216; i++) a_z[i*32 +: 32] = $urandom();
        for (int i = 0; i < 64; i++)   b_seed[i*32 +: 32] = $urandom();
        for (int i = 0; i < 128; i++)  b_cv[i*32 +: 32] = $urandom();
        for (int i = 0; i < 2432; i++) b_z[i*32 +: 32] = $urandom();
    endtask

    // Starts a frame on dut_a and follows it until done or the budget runs out.
    task automatic run_frame(input bit hold, input int budget, output int first, output logic [63:0] d0,
                             output int lastc, output int donec, output logic bz, output logic e1);
        first = -1; lastc = -1; donec = -1; d0 = '0; bz = 1'bx; e1 = 1'bx;
        @(negedge clk);
        a_start = 1'b1;
        for (int c = 1; c <= budget && donec < 0; c++) begin
            @(negedge clk); #1;
            if (c == 1) begin e1 = a_err; if (!hold) a_start = 1'b0; end
            if (a_out_valid && first < 0) begin first = c; d0 = a_out_data; end
            if (a_out_valid && a_out_ready && a_out_last) lastc = c;
            if (a_done) begin donec = c; bz = a_busy; end
        end
    endtask

    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            a_out_ready = a_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [99:0] ea;
        bit el;
        forever begin
            @(negedge clk);
            if (!reset) a_prev_stall = 1'b0;
            else begin
                if (a_prev_stall) begin
                    tests++;
                    if (a_out_valid !== 1'b1 || a_out_data !== a_prev_data) begin
                        fails++;
                        $display("FAIL a_stall_hold: valid=%b data=%h, required valid=1 data=%h", a_out_valid, a_out_data, a_prev_data);
                    end
                end
                if (a_out_valid && a_out_ready) begin
                    tests++;
                    if (exp_a.size() == 0) begin
                        fails++;
                        $display("FAIL a_extra_beat: got data=%h with no beat expected", a_out_data);
                    end else begin
                        ea = exp_a.pop_front(); el = exl_a.pop_front();
                        if (a_out_data !== ea[63:0] || a_out_last !== el) begin
                            fails++;
                            $display("FAIL a_beat %0d: data=%h last=%b, required data=%h last=%b", a_beats, a_out_data, a_out_last, ea[63:0], el);
                        end
                    end
                    a_beats++;
                end
                a_prev_stall = a_out_valid && !a_out_ready;
                a_prev_data  = a_out_data;
            end
        end
    end

    initial begin
        logic [99:0] eb;
        bit el;
        forever begin
            @(negedge clk);
            if (reset && b_out_valid && b_out_ready) begin
                tests++;
                if (exp_b.size() == 0) begin
                    fails++;
                    $display("FAIL b_extra_beat: got data=%h with no beat expected", b_out_data);
                end else begin
                    eb = exp_b.pop_front(); el = exl_b.pop_front();
                    if (b_out_data !== eb || b_out_last !== el) begin
                        fails++;
                        $display("FAIL b_beat %0d: data=%h last=%b, required data=%h last=%b", b_beats, b_out_data, b_out_last, eb, el);
                    end
                end
                b_beats++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0; a_start = 1'b0; b_start = 1'b0; a_lc = '0; b_lc = '0; b_out_ready = 1'b1;
        rand_inputs();
        repeat (2) @(negedge clk);
        tests++;
        if ({a_out_data, a_out_valid, a_out_last, a_busy, a_done, a_err} !== 69'd0) begin
            fails++;
            $display("FAIL reset_a: outputs=%h, required 0", {a_out_data, a_out_valid, a_out_last, a_busy, a_done, a_err});
        end
        tests++;
        if ({b_out_data, b_out_valid, b_out_last, b_busy, b_done, b_err} !== 105'd0) begin
            fails++;
            $display("FAIL reset_b: outputs=%h, required 0", {b_out_data, b_out_valid, b_out_last, b_busy, b_done, b_err});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame_end(input string nm, input int lastc, input int donec, input logic bz, input int nb);
        tests++;
        if (a_beats !== nb || exp_a.size() != 0) begin
            fails++;
            $display("FAIL %s_beats: beats=%0d left=%0d, required beats=%0d left=0", nm, a_beats, exp_a.size(), nb);
        end
        tests++;
        if (donec < 0 || donec != lastc + 1 || bz !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: done_cycle=%0d last_cycle=%0d busy=%b, required done_cycle=last+1 busy=0", nm, donec, lastc, bz);
        end
    endtask

    task automatic test_basic();
        int first, lastc, donec; logic [63:0] d0; logic bz, e1;
        a_lc = {5'd1, 5'd3, 5'd4, 5'd6};
        model_a(a_lc);
        a_beats = 0;
        run_frame(1'b0, 1000, first, d0, lastc, donec, bz, e1);
        tests++;
        if (first != 14 || d0 !== a_h_t[255:192]) begin
            fails++;
            $display("FAIL basic_first: cycle=%0d data=%h, required cycle=14 data=%h", first, d0, a_h_t[255:192]);
        end
        check_frame_end("basic", lastc, donec, bz, 338);
    endtask

    task automatic test_stall();
        int first, lastc, donec; logic [63:0] d0; logic bz, e1;
        model_a(a_lc);
        a_beats = 0;
        a_rand_ready = 1'b1;
        run_frame(1'b0, 3000, first, d0, lastc, donec, bz, e1);
        a_rand_ready = 1'b0;
        check_frame_end("stall", lastc, donec, bz, 338);
    endtask

    task automatic test_err(input string nm, input logic [19:0] lcv);
        int donec, ndone; logic anyv, err5;
        donec = -1; ndone = 0; anyv = 1'b0; err5 = 1'bx;
        a_lc = lcv;
        @(negedge clk);
        a_start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk); #1;
            if (c == 1) a_start = 1'b0;
            if (a_out_valid) anyv = 1'b1;
            if (a_done) begin ndone++; if (donec < 0) donec = c; end
            if (c == 5) err5 = a_err;
        end
        tests++;
        if (donec != 5 || ndone != 1 || err5 !== 1'b1) begin
            fails++;
            $display("FAIL %s_done_err: done_cycle=%0d pulses=%0d err@5=%b, required 5/1/1", nm, donec, ndone, err5);
        end
        tests++;
        if (anyv !== 1'b0 || a_err !== 1'b1) begin
            fails++;
            $display("FAIL %s_hold: any_valid=%b err=%b, required any_valid=0 err=1", nm, anyv, a_err);
        end
    endtask

    task automatic test_reset_mid();
        int first, lastc, donec, ndone; logic [63:0] d0; logic bz, e1;
        a_lc = {5'd1, 5'd3, 5'd4, 5'd6};
        model_a(a_lc);
        a_beats = 0;
        @(negedge clk);
        a_start = 1'b1;
        for (int c = 1; c <= 500 && a_beats < 100; c++) begin
            @(negedge clk); #1;
            if (c == 1) a_start = 1'b0;
        end
        reset = 1'b0;
        #1;
        tests++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_beats != 100) begin
            fails++;
            $display("FAIL midreset_clear: valid=%b busy=%b beats=%0d, required valid=0 busy=0 beats=100", a_out_valid, a_busy, a_beats);
        end
        ndone = 0;
        repeat (3) begin @(negedge clk); #1; if (a_done) ndone++; end
        exp_a.delete(); exl_a.delete();
        reset = 1'b1;
        repeat (2) begin @(negedge clk); #1; if (a_done) ndone++; end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL midreset_nodone: done pulses=%0d, required 0", ndone);
        end
        model_a(a_lc);
        a_beats = 0;
        run_frame(1'b0, 1000, first, d0, lastc, donec, bz, e1);
        tests++;
        if (first != 14 || e1 !== 1'b0) begin
            fails++;
            $display("FAIL restart_first: cycle=%0d err=%b, required cycle=14 err=0", first, e1);
        end
        check_frame_end("restart", lastc, donec, bz, 338);
    endtask

    task automatic test_back_to_back();
        int first, lastc, donec, k, donec2; logic [63:0] d0; logic bz, e1;
        a_lc = {5'd0, 5'd2, 5'd5, 5'd7};
        model_a(a_lc);
        model_a(a_lc);
        a_beats = 0;
        run_frame(1'b1, 1000, first, d0, lastc, donec, bz, e1);
        k = 0;
        while (k < 40 && !a_out_valid) begin @(negedge clk); #1; k++; end
        a_start = 1'b0;
        tests++;
        if (first != 14 || k != 15) begin
            fails++;
            $display("FAIL b2b_latency: first=%0d second_offset=%0d, required 14 and 15", first, k);
        end
        donec2 = -1;
        for (int c = 0; c < 1000 && donec2 < 0; c++) begin
            @(negedge clk); #1;
            if (a_done) donec2 = c;
        end
        tests++;
        if (donec2 < 0 || a_beats != 676 || exp_a.size() != 0) begin
            fails++;
            $display("FAIL b2b_frames: beats=%0d left=%0d done=%0d, required beats=676 left=0", a_beats, exp_a.size(), donec2);
        end
    endtask

    task automatic test_wide();
        int first, donec; logic [99:0] lastd;
        first = -1; donec = -1; lastd = '0;
        b_lc = {5'd15, 5'd0};
        model_b(b_lc);
        b_beats = 0;
        @(negedge clk);
        b_start = 1'b1;
        for (int c = 1; c <= 400 && donec < 0; c++) begin
            @(negedge clk); #1;
            if (c == 1) b_start = 1'b0;
            if (b_out_valid && first < 0) first = c;
            if (b_out_valid && b_out_last) lastd = b_out_data;
            if (b_done) donec = c;
        end
        tests++;
        if (first != 20 || donec < 0 || b_beats != 158 || exp_b.size() != 0) begin
            fails++;
            $display("FAIL wide_frame: first=%0d done=%0d beats=%0d left=%0d, required first=20 beats=158 left=0", first, donec, b_beats, exp_b.size());
        end
        tests++;
        if (lastd !== {a_tri[43:0], 56'd0}) begin
            fails++;
            $display("FAIL wide_last: data=%h, required %h", lastd, {a_tri[43:0], 56'd0});
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_err("dup", {5'd2, 5'd2, 5'd5, 5'd7});
        test_err("range", {5'd0, 5'd8, 5'd3, 5'd1});
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
